// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface multicycle_controller_if;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;

    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       Branch;
    logic       PCWrite;
    logic       PCEn;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic [3:0] State;

    modport master (
        input  Op, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, Branch, PCWrite, PCEn, ALUSrcB, ALUOp, PCSrc, State
    );

    modport slave (
        output Op, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, Branch, PCWrite, PCEn, ALUSrcB, ALUOp, PCSrc, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle MIPS datapath (R-type, lw, sw, beq, addi, j).
// Defining MULTICYCLE_BNE_EN adds a bne state (code 12) that branches on ~Zero.
module multicycle_controller (
    input logic                     clk,
    input logic                     rst_n,
    multicycle_controller_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
`ifdef MULTICYCLE_BNE_EN
        JUMP   = 4'd11,
        BNE    = 4'd12
`else
        JUMP   = 4'd11
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       branch;
    logic       pc_write;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
`ifdef MULTICYCLE_BNE_EN
    logic       branch_ne;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = BNE;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            // Op is re-examined here; anything but lw/sw abandons the access.
            MEMADR: begin
                if (bus.Op == OP_SW) begin
                    state_d = MEMWR;
                end else if (bus.Op == OP_LW) begin
                    state_d = MEMRD;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:  state_d = bus.MemReady ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = bus.MemReady ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BEQ:    state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            JUMP:   state_d = FETCH;
`ifdef MULTICYCLE_BNE_EN
            BNE:    state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Outputs are gated by rst_n directly so an in-flight access drops
    // the instant reset asserts, without waiting for a clock edge.
    always_comb begin
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_dst   = 1'b0;
        memto_reg = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        branch    = 1'b0;
        pc_write  = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        pc_src    = 2'b00;
`ifdef MULTICYCLE_BNE_EN
        branch_ne = 1'b0;
`endif
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = bus.MemReady;
                    pc_write  = bus.MemReady;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                end
                MEMADR, ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                MEMWB: begin
                    memto_reg = 1'b1;
                    reg_write = 1'b1;
                end
                MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                BEQ: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    branch    = 1'b1;
                end
                ADDIWB: begin
                    reg_write = 1'b1;
                end
                JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
`ifdef MULTICYCLE_BNE_EN
                BNE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    branch_ne = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign bus.IorD     = iord;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.IRWrite  = ir_write;
    assign bus.RegDst   = reg_dst;
    assign bus.MemtoReg = memto_reg;
    assign bus.RegWrite = reg_write;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.Branch   = branch;
    assign bus.PCWrite  = pc_write;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.ALUOp    = alu_op;
    assign bus.PCSrc    = pc_src;
    assign bus.State    = state_q;

`ifdef MULTICYCLE_BNE_EN
    assign bus.PCEn = pc_write | (branch & bus.Zero) | (branch_ne & ~bus.Zero);
`else
    assign bus.PCEn = pc_write | (branch & bus.Zero);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class with
// hand-computed state/control sequences, including stalls and async reset.
module tb_multicycle_controller;

    logic clk;
    logic rst_n;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,Branch,PCWrite,PCEn,ALUSrcB,ALUOp,PCSrc}
    logic [16:0] ctl;
    assign ctl = {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                  bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.Branch, bus.PCWrite,
                  bus.PCEn, bus.ALUSrcB, bus.ALUOp, bus.PCSrc};

    localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_F1     = 17'b0_1_0_1_0_0_0_0_0_1_1_01_00_00;
    localparam logic [16:0] C_F0     = 17'b0_1_0_0_0_0_0_0_0_0_0_01_00_00;
    localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_1_0_0_0_10_00_00;
    localparam logic [16:0] C_MEMRD  = 17'b1_1_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_1_1_0_0_0_0_00_00_00;
    localparam logic [16:0] C_MEMWR  = 17'b1_0_1_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_1_0_0_0_00_10_00;
    localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_1_0_1_0_0_0_0_00_00_00;
    localparam logic [16:0] C_BEQ_T  = 17'b0_0_0_0_0_0_0_1_1_0_1_00_01_01;
    localparam logic [16:0] C_BEQ_N  = 17'b0_0_0_0_0_0_0_1_1_0_0_00_01_01;
    localparam logic [16:0] C_ADDIWB = 17'b0_0_0_0_0_0_1_0_0_0_0_00_00_00;
    localparam logic [16:0] C_JUMP   = 17'b0_0_0_0_0_0_0_0_0_1_1_00_00_10;
    localparam logic [16:0] C_BNE_T  = 17'b0_0_0_0_0_0_0_1_0_0_1_00_01_01;

    int vectors;
    int miscompares;

    task automatic test_reset;
        rst_n = 1'b1;
        bus.Op = 6'b100011;
        bus.Zero = 1'b0;
        bus.MemReady = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.State, ctl} !== {4'd0, C_ZERO}) begin
            miscompares++;
            $display("FAIL reset_async: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_ZERO);
        end
        @(negedge clk);
        vectors++;
        if ({bus.State, ctl} !== {4'd0, C_ZERO}) begin
            miscompares++;
            $display("FAIL reset_held: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_ZERO);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({bus.State, ctl} !== {4'd0, C_F1}) begin
            miscompares++;
            $display("FAIL reset_release: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_F1);
        end
    endtask

    task automatic test_lw;
        logic [3:0]  st [6];
        logic [16:0] cv [6];
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        cv = '{C_F1, C_DEC, C_MEMADR, C_MEMRD, C_MEMWB, C_F1};
        bus.Op = 6'b100011;
        bus.Zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.MemReady = 1'b1;
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL lw cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < 5) @(negedge clk);
        end
    endtask

    task automatic test_lw_stall;
        logic [3:0]  st [8];
        logic [16:0] cv [8];
        logic        rdy [8];
        logic [5:0]  op [8];
        st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        cv  = '{C_F1, C_DEC, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB, C_F1};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        op  = '{6'b100011, 6'b100011, 6'b100011, 6'b000000, 6'b000100, 6'b000000, 6'b000010, 6'b100011};
        bus.Zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.MemReady = rdy[i];
            bus.Op = op[i];
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL lw_stall cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < 7) @(negedge clk);
        end
    endtask

    task automatic test_sw_stall;
        logic [3:0]  st [8];
        logic [16:0] cv [8];
        logic        rdy [8];
        st  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        cv  = '{C_F1, C_DEC, C_MEMADR, C_MEMWR, C_MEMWR, C_MEMWR, C_MEMWR, C_F1};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.Op = 6'b101011;
        bus.Zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.MemReady = rdy[i];
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL sw_stall cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < 7) @(negedge clk);
        end
    endtask

    task automatic test_rtype_fetch_stall;
        logic [3:0]  st [7];
        logic [16:0] cv [7];
        logic        rdy [7];
        st  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        cv  = '{C_F0, C_F0, C_F1, C_DEC, C_EXEC, C_ALUWB, C_F1};
        rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        bus.Op = 6'b000000;
        bus.Zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.MemReady = rdy[i];
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL rtype cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < 6) @(negedge clk);
        end
    endtask

    task automatic test_beq(input logic zero);
        logic [3:0]  st [4];
        logic [16:0] cv [4];
        st = '{4'd0, 4'd1, 4'd8, 4'd0};
        cv = '{C_F1, C_DEC, (zero ? C_BEQ_T : C_BEQ_N), C_F1};
        bus.Op = 6'b000100;
        bus.Zero = zero;
        for (int i = 0; i < 4; i++) begin
            bus.MemReady = 1'b1;
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL beq zero=%0b cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", zero, i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_addi_op_ignored;
        logic [3:0]  st [5];
        logic [16:0] cv [5];
        logic [5:0]  op [5];
        st = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        cv = '{C_F1, C_DEC, C_MEMADR, C_ADDIWB, C_F1};
        op = '{6'b001000, 6'b001000, 6'b000010, 6'b101011, 6'b001000};
        bus.Zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.MemReady = 1'b1;
            bus.Op = op[i];
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL addi cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_jump;
        logic [3:0]  st [4];
        logic [16:0] cv [4];
        st = '{4'd0, 4'd1, 4'd11, 4'd0};
        cv = '{C_F1, C_DEC, C_JUMP, C_F1};
        bus.Op = 6'b000010;
        bus.Zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.MemReady = 1'b1;
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL jump cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < 3) @(negedge clk);
        end
    endtask

    task automatic test_unknown_op;
        logic [3:0]  st [3];
        logic [16:0] cv [3];
        st = '{4'd0, 4'd1, 4'd0};
        cv = '{C_F1, C_DEC, C_F1};
        bus.Op = 6'b111111;
        bus.Zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.MemReady = 1'b1;
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL unknown_op cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < 2) @(negedge clk);
        end
    endtask

    task automatic test_bne;
        logic [3:0]  st [4];
        logic [16:0] cv [4];
        int          n;
`ifdef MULTICYCLE_BNE_EN
        st = '{4'd0, 4'd1, 4'd12, 4'd0};
        cv = '{C_F1, C_DEC, C_BNE_T, C_F1};
        n  = 4;
`else
        st = '{4'd0, 4'd1, 4'd0, 4'd0};
        cv = '{C_F1, C_DEC, C_F1, C_F1};
        n  = 3;
`endif
        bus.Op = 6'b000101;
        bus.Zero = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.MemReady = 1'b1;
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL bne cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < n - 1) @(negedge clk);
        end
    endtask

    task automatic test_async_reset_memwr;
        logic [3:0]  st [4];
        logic [16:0] cv [4];
        logic        rdy [4];
        st  = '{4'd0, 4'd1, 4'd2, 4'd5};
        cv  = '{C_F1, C_DEC, C_MEMADR, C_MEMWR};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus.Op = 6'b101011;
        bus.Zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.MemReady = rdy[i];
            #1;
            vectors++;
            if ({bus.State, ctl} !== {st[i], cv[i]}) begin
                miscompares++;
                $display("FAIL rst_memwr cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, st[i], cv[i]);
            end
            if (i < 3) @(negedge clk);
        end
        // Mid-cycle, well before the next rising edge.
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.State, ctl} !== {4'd0, C_ZERO}) begin
            miscompares++;
            $display("FAIL rst_memwr_abort: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_ZERO);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.State, ctl} !== {4'd0, C_ZERO}) begin
            miscompares++;
            $display("FAIL rst_memwr_held: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_ZERO);
        end
        @(negedge clk);
        bus.Op = 6'b111111;
        bus.MemReady = 1'b1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({bus.State, ctl} !== {4'd0, C_F1}) begin
            miscompares++;
            $display("FAIL rst_release_fetch: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_F1);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({bus.State, ctl} !== {4'd1, C_DEC}) begin
            miscompares++;
            $display("FAIL rst_release_decode: state=%0d ctl=%b, expected state=1 ctl=%b", bus.State, ctl, C_DEC);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({bus.State, ctl} !== {4'd0, C_F1}) begin
            miscompares++;
            $display("FAIL rst_release_refetch: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_F1);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_lw();
        test_lw_stall();
        test_sw_stall();
        test_rtype_fetch_stall();
        test_beq(1'b1);
        test_beq(1'b0);
        test_addi_op_ignored();
        test_jump();
        test_unknown_op();
        test_bne();
        test_async_reset_memwr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings SHALL be fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 Op  input  6  opcode from instruction register; R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 MemReady  input  1  memory handshake; access completes in any cycle where it is 1.
REQ-007 IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite, PCEn  output  1 each  datapath controls.
REQ-008 ALUSrcB, ALUOp, PCSrc  output  2 each  mux/ALU selects (ALUOp: 00 add, 01 sub, 10 funct).
REQ-009 State  output  4  current state code, for debug.

Function
REQ-010 The block SHALL be a Moore FSM; codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-011 Outputs not listed for a state SHALL be 0.
REQ-012 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=MemReady; stay while MemReady=0, go DECODE when 1.
REQ-013 DECODE: ALUSrcB=11, ALUOp=00; next by Op: lw/sw->MEMADR, R-type->EXEC, beq->BEQ, addi->ADDIEX, j->JUMP, any other->FETCH (instruction ignored, no writes).
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if lw, MEMWR if sw.
REQ-015 MEMRD: IorD=1, MemRead=1; hold until MemReady=1, then MEMWB.
REQ-016 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-017 MEMWR: IorD=1, MemWrite=1 held every cycle until MemReady=1; then FETCH.
REQ-018 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB.
REQ-019 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-020 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1; next FETCH.
REQ-021 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB.
REQ-022 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-023 JUMP: PCSrc=10, PCWrite=1; next FETCH.
REQ-024 PCEn SHALL equal PCWrite | (Branch & Zero), combinationally.
REQ-025 Zero-wait latency in cycles, FETCH to next FETCH: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3; each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one.
REQ-026 Op SHALL be used only in DECODE and MEMADR; changes elsewhere SHALL have no effect.
REQ-027 Unused state codes (12-15) SHALL transition to FETCH next cycle with all outputs 0.

Reset
REQ-028 rst_n=0 SHALL force State=FETCH immediately, independent of clk.
REQ-029 While rst_n=0 all outputs SHALL be 0 except State=0, including during an in-flight MEMWR or MEMRD (access abandoned).
REQ-030 First rising edge after rst_n rises SHALL evaluate FETCH normally.

Configuration
REQ-031 Macro MULTICYCLE_BNE_EN: when defined, Op 000101 (bne) in DECODE SHALL go to state BNE=12 with ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, an internal BranchNe=1, and PCEn SHALL additionally include BranchNe & ~Zero; Branch stays 0 in BNE; next FETCH.
REQ-032 When undefined, Op 000101 SHALL be treated as unknown (DECODE->FETCH) and state 12 SHALL behave per REQ-027.

Verification
REQ-033 Reset then MemReady=1, Op=100011 -> States 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-034 Op=101011, MemReady=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, then State=0.
REQ-035 Op=000100 with Zero=1 -> PCEn=1 in BEQ; with Zero=0 -> PCEn=0; both return to FETCH after 3 cycles.
REQ-036 Op=111111 -> DECODE->FETCH, RegWrite/MemWrite/PCEn never asserted outside FETCH.
REQ-037 rst_n pulled low mid-MEMWR asynchronously -> MemWrite=0 and State=0 before next clk edge.
REQ-038 With MULTICYCLE_BNE_EN, Op=000101, Zero=0 -> State 12, PCEn=1; without macro -> State 1->0, PCEn=0.
